vec_assembler: RTL

//  Receive side of the popcount stage's output stream. Collects SUB_VECTOR_NO bus-wide sub-vector beats into one

---
 rtl/fp_pkg.sv | 13 +
 rtl/vec_assembler_if.sv | 28 ++
 rtl/vec_assembler_fifo.sv | 54 +++++
 rtl/vec_assembler.sv | 80 ++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Fingerprint pipeline shared defaults: vector/bus/weight widths and the beat-index sizing helper.
package fp_pkg;

  localparam int unsigned VECTOR_WIDTH  = 920;
  localparam int unsigned BUS_WIDTH     = 512;
  localparam int unsigned SUB_VECTOR_NO = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int unsigned CNT_WIDTH     = $clog2(VECTOR_WIDTH);

  function automatic int unsigned beat_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_assembler_if.sv
// Upstream beat/weight stream plus downstream valid/ready port of the vector assembler.
interface vec_assembler_if #(
  parameter int unsigned VECTOR_WIDTH = fp_pkg::VECTOR_WIDTH,
  parameter int unsigned BUS_WIDTH    = fp_pkg::BUS_WIDTH,
  parameter int unsigned CNT_WIDTH    = fp_pkg::CNT_WIDTH
);

  logic [BUS_WIDTH-1:0]    i_SubVector;
  logic                    i_Valid;
  logic [CNT_WIDTH-1:0]    i_Cnt;
  logic                    i_CntNew;
  logic [VECTOR_WIDTH-1:0] o_Vector;
  logic [CNT_WIDTH-1:0]    o_Cnt;
  logic                    o_Valid;
  logic                    i_Ready;
  logic                    o_Overflow;

  modport slave (
    input  i_SubVector, i_Valid, i_Cnt, i_CntNew, i_Ready,
    output o_Vector, o_Cnt, o_Valid, o_Overflow
  );

  modport master (
    output i_SubVector, i_Valid, i_Cnt, i_CntNew, i_Ready,
    input  o_Vector, o_Cnt, o_Valid, o_Overflow
  );

endinterface

// File: rtl/vec_assembler_fifo.sv
// Small synchronous first-word-fall-through FIFO; a push is accepted when full if a pop happens the same cycle.
module sync_fifo_small #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic             do_pop, do_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vec_assembler.sv
// Assembles bus-wide beats into fingerprints, pairs each with its weight in arrival order,
// and presents the pair on a valid/ready port; drops on full queues set a sticky overflow flag.
module vec_assembler
  import fp_pkg::*;
#(
  parameter int unsigned VECTOR_WIDTH  = fp_pkg::VECTOR_WIDTH,
  parameter int unsigned BUS_WIDTH     = fp_pkg::BUS_WIDTH,
  parameter int unsigned SUB_VECTOR_NO = fp_pkg::SUB_VECTOR_NO,
  parameter int unsigned CNT_WIDTH     = fp_pkg::CNT_WIDTH,
  parameter int unsigned DEPTH         = 2
) (
  input  logic            clk,
  input  logic            rst,
  vec_assembler_if.slave  bus
);

  localparam int unsigned IDX_W = beat_idx_width(SUB_VECTOR_NO);
  localparam int unsigned ASM_W = (SUB_VECTOR_NO - 1) * BUS_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SUB_VECTOR_NO - 1);

  logic [IDX_W-1:0]        idx_q;
  logic [ASM_W-1:0]        asm_q;
  logic [VECTOR_WIDTH-1:0] vec_in;
  logic                    last_beat;
  logic                    ovf_q;
  logic                    pop, valid;
  logic                    v_full, v_empty, c_full, c_empty;
  logic                    v_drop, c_drop;

  // The last beat bypasses the assembly register so the complete vector is queued the same cycle;
  // beat bits beyond VECTOR_WIDTH fall off in the truncation.
  assign last_beat = bus.i_Valid && (idx_q == LAST_IDX);
  assign vec_in    = VECTOR_WIDTH'({bus.i_SubVector, asm_q});

  assign valid = ~v_empty & ~c_empty;
  assign pop   = valid & bus.i_Ready;

  assign v_drop = last_beat    & v_full & ~pop;
  assign c_drop = bus.i_CntNew & c_full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      asm_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (bus.i_Valid) begin
        idx_q <= last_beat ? '0 : idx_q + IDX_W'(1);
        if (!last_beat) asm_q[idx_q*BUS_WIDTH +: BUS_WIDTH] <= bus.i_SubVector;
      end
      ovf_q <= ovf_q | v_drop | c_drop;
    end
  end

  sync_fifo_small #(.WIDTH(VECTOR_WIDTH), .DEPTH(DEPTH)) u_vec_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (last_beat),
    .din   (vec_in),
    .pop   (pop),
    .dout  (bus.o_Vector),
    .full  (v_full),
    .empty (v_empty)
  );

  sync_fifo_small #(.WIDTH(CNT_WIDTH), .DEPTH(DEPTH)) u_cnt_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.i_CntNew),
    .din   (bus.i_Cnt),
    .pop   (pop),
    .dout  (bus.o_Cnt),
    .full  (c_full),
    .empty (c_empty)
  );

  assign bus.o_Valid    = valid;
  assign bus.o_Overflow = ovf_q;

endmodule
